video_input_timing_monitor: RTL

//  Upstream stage ahead of the colorspace converter, on the pixel clock domain.

---
 rtl/video_input_timing_monitor.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/video_input_timing_monitor.sv
// Video input timing monitor: registers VGA pixels/syncs, tags active pixels with column/row,
// measures line and frame timing and tracks lock. VIDEO_TIMING_MON_STATS_EN adds O_ERR_FRAMES.
//
// state   | meaning
// SEARCH  | no frame boundary seen since reset
// ACQUIRE | counting consecutive conforming frames toward lock
// LOCKED  | timing conforms; a bad frame drops back to ACQUIRE
module video_input_timing_monitor #(
  parameter int H_ACT       = 640,
  parameter int V_ACT       = 480,
  parameter int LOCK_FRAMES = 2,
  parameter int CNT_W       = 12
) (
  input  logic                     I_PCLK,
  input  logic                     I_RST_N,
  input  logic [23:0]              I_PIX_DATA,
  input  logic                     I_VSYNC,
  input  logic                     I_HSYNC,
  input  logic                     I_DE,
  output logic [23:0]              O_PIX_DATA,
  output logic                     O_DE,
  output logic [$clog2(H_ACT)-1:0] O_COL,
  output logic [$clog2(V_ACT)-1:0] O_ROW,
  output logic                     O_SOF,
  output logic                     O_EOL,
  output logic                     O_EOF,
  output logic                     O_LOCKED,
  output logic                     O_ERR,
  output logic [CNT_W-1:0]         O_LINE_LEN,
`ifdef VIDEO_TIMING_MON_STATS_EN
  output logic [CNT_W-1:0]         O_FRAME_LINES,
  output logic [15:0]              O_ERR_FRAMES
`else
  output logic [CNT_W-1:0]         O_FRAME_LINES
`endif
);

  localparam int COL_W = $clog2(H_ACT);
  localparam int ROW_W = $clog2(V_ACT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] H_LEN   = CNT_W'(H_ACT);
  localparam logic [CNT_W-1:0] V_LEN   = CNT_W'(V_ACT);
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_ACT - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_ACT - 1);
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;

  state_t           state;
  logic             vs_q, line_open, line_bad, sof_pend;
  logic [CNT_W-1:0] pix_cnt, line_cnt;
  logic [3:0]       good_cnt;

  logic             vs_rise, line_start, trunc, line_end, frame_good;
  logic [CNT_W-1:0] pix_idx, pix_len, end_len, lines_now;
  logic             hsync_unused;

  // Line timing is derived from DE; HSYNC is accepted but not needed.
  assign hsync_unused = I_HSYNC;

  // A VSYNC rise while DE is high closes the open line together with the frame.
  always_comb begin
    vs_rise    = I_VSYNC & ~vs_q;
    line_start = I_DE & ~line_open;
    trunc      = vs_rise & I_DE;
    line_end   = (line_open & ~I_DE) | trunc;
    pix_idx    = line_start ? '0 : pix_cnt;
    pix_len    = (pix_idx == CNT_MAX) ? CNT_MAX : pix_idx + 1'b1;
    end_len    = I_DE ? pix_len : pix_cnt;
    lines_now  = line_cnt;
    if (line_end && (line_cnt != CNT_MAX)) lines_now = line_cnt + 1'b1;
    frame_good = (lines_now == V_LEN) && !line_bad && !trunc
                 && !(line_end && (end_len != H_LEN));
  end

  always_ff @(posedge I_PCLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state         <= SEARCH;
      vs_q          <= 1'b0;
      line_open     <= 1'b0;
      line_bad      <= 1'b0;
      sof_pend      <= 1'b0;
      pix_cnt       <= '0;
      line_cnt      <= '0;
      good_cnt      <= '0;
      O_PIX_DATA    <= '0;
      O_DE          <= 1'b0;
      O_COL         <= '0;
      O_ROW         <= '0;
      O_SOF         <= 1'b0;
      O_EOL         <= 1'b0;
      O_EOF         <= 1'b0;
      O_LOCKED      <= 1'b0;
      O_ERR         <= 1'b0;
      O_LINE_LEN    <= '0;
      O_FRAME_LINES <= '0;
`ifdef VIDEO_TIMING_MON_STATS_EN
      O_ERR_FRAMES  <= '0;
`endif
    end else begin
      O_PIX_DATA <= I_PIX_DATA;
      O_DE       <= I_DE;
      vs_q       <= I_VSYNC;
      line_open  <= I_DE & ~vs_rise;
      O_SOF      <= 1'b0;
      O_EOL      <= 1'b0;
      O_EOF      <= 1'b0;
      O_ERR      <= 1'b0;

      if (I_DE) begin
        pix_cnt <= pix_len;
        O_COL   <= (pix_idx >= H_LAST) ? COL_W'(H_ACT - 1) : pix_idx[COL_W-1:0];
        O_ROW   <= (line_cnt >= V_LAST) ? ROW_W'(V_ACT - 1) : line_cnt[ROW_W-1:0];
        if (line_start && sof_pend && !vs_rise) begin
          O_SOF    <= 1'b1;
          sof_pend <= 1'b0;
        end
      end

      if (line_end) begin
        O_EOL      <= 1'b1;
        O_LINE_LEN <= end_len;
      end

      if (vs_rise) begin
        O_EOF         <= 1'b1;
        O_FRAME_LINES <= lines_now;
        line_cnt      <= '0;
        line_bad      <= 1'b0;
        sof_pend      <= 1'b1;
        case (state)
          SEARCH: begin
            state    <= ACQUIRE;
            good_cnt <= '0;
          end
          ACQUIRE: begin
            if (frame_good) begin
              good_cnt <= good_cnt + 4'd1;
              if ((good_cnt + 4'd1) >= LOCK_N) begin
                state    <= LOCKED;
                O_LOCKED <= 1'b1;
              end
            end else begin
              good_cnt <= '0;
            end
          end
          LOCKED: begin
            if (!frame_good) begin
              state    <= ACQUIRE;
              good_cnt <= '0;
              O_LOCKED <= 1'b0;
              O_ERR    <= 1'b1;
`ifdef VIDEO_TIMING_MON_STATS_EN
              if (O_ERR_FRAMES != 16'hFFFF) O_ERR_FRAMES <= O_ERR_FRAMES + 16'd1;
`endif
            end
          end
          default: state <= SEARCH;
        endcase
      end else if (line_end) begin
        line_cnt <= lines_now;
        if (end_len != H_LEN) line_bad <= 1'b1;
      end
    end
  end

endmodule
